// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage and the long-latency unit.
// It also keeps a pending scoreboard of destinations still owed a long writeback.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PipeWrite,
  input  logic [4:0]  PipeAddr,
  input  logic [31:0] PipeData,
  output logic        PipeStall,
  input  logic        LongValid,
  input  logic [4:0]  LongAddr,
  input  logic [31:0] LongData,
  output logic        LongReady,
  input  logic        IssueLong,
  input  logic [4:0]  IssueAddr,
  input  logic [4:0]  RsAddr,
  input  logic [4:0]  RtAddr,
  output logic        RsBusy,
  output logic        RtBusy,
  output logic        RegWrite,
  output logic [4:0]  RdAddr,
  output logic [31:0] RdData,
  output logic [5:0]  PendingCount,
  output logic        IssueError
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  function automatic logic [5:0] popcount32(input logic [31:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

  // Register 0 is hard-wired, so it never yields a scoreboard bit.
  function automatic logic [31:0] onehot32(input logic [4:0] addr, input logic en);
    logic [31:0] vec;
    vec = 32'd0;
    if (en && (addr != 5'd0)) begin
      vec[addr] = 1'b1;
    end else begin
      vec = 32'd0;
    end
    return vec;
  endfunction

  logic [31:0] pending_r;
  logic [3:0]  starve_cnt_r;
  logic [5:0]  pending_cnt_r;
  logic        issue_error_r;

  logic        starved_s;
  logic        grant_long_s;
  logic        grant_pipe_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic [31:0] set_vec_s;
  logic [31:0] clr_vec_s;
  logic [31:0] pending_next_s;
  logic [3:0]  starve_next_s;
  logic        reissue_err_s;
  logic        orphan_err_s;

  // Grant decision; reset suppresses both handshakes immediately.
  always_comb begin
    starved_s    = (starve_cnt_r == STARVE_MAX);
    grant_long_s = ~Reset & LongValid & (~PipeWrite | starved_s);
    grant_pipe_s = ~Reset & PipeWrite & ~grant_long_s;
  end

  // Write-port mux driven by whichever source won this cycle.
  always_comb begin
    wr_addr_s = 5'd0;
    wr_data_s = 32'd0;
    if (grant_long_s) begin
      wr_addr_s = LongAddr;
      wr_data_s = LongData;
    end else if (grant_pipe_s) begin
      wr_addr_s = PipeAddr;
      wr_data_s = PipeData;
    end else begin
      wr_addr_s = 5'd0;
      wr_data_s = 32'd0;
    end
  end

  assign LongReady = grant_long_s;
  assign PipeStall = PipeWrite & grant_long_s;
  assign RegWrite  = (grant_long_s | grant_pipe_s) & (wr_addr_s != 5'd0);
  assign RdAddr    = wr_addr_s;
  assign RdData    = wr_data_s;

  assign RsBusy       = (RsAddr != 5'd0) & pending_r[RsAddr];
  assign RtBusy       = (RtAddr != 5'd0) & pending_r[RtAddr];
  assign PendingCount = pending_cnt_r;
  assign IssueError   = issue_error_r;

  // Next scoreboard value and protocol checks; a same-cycle set beats the clear.
  always_comb begin
    set_vec_s      = onehot32(IssueAddr, IssueLong);
    clr_vec_s      = onehot32(LongAddr, grant_long_s);
    pending_next_s = ((pending_r & ~clr_vec_s) | set_vec_s) & 32'hFFFF_FFFE;
    reissue_err_s  = IssueLong & (IssueAddr != 5'd0) & pending_r[IssueAddr]
                     & ~clr_vec_s[IssueAddr];
    orphan_err_s   = grant_long_s & (LongAddr != 5'd0) & ~pending_r[LongAddr];
  end

  // Starvation counter counts refused long cycles and saturates at the limit.
  always_comb begin
    starve_next_s = 4'd0;
    if (LongValid & ~grant_long_s) begin
      if (starved_s) begin
        starve_next_s = starve_cnt_r;
      end else begin
        starve_next_s = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_next_s = 4'd0;
    end
  end

  // State registers; count tracks the scoreboard on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending_r     <= 32'd0;
      starve_cnt_r  <= 4'd0;
      pending_cnt_r <= 6'd0;
      issue_error_r <= 1'b0;
    end else begin
      pending_r     <= pending_next_s;
      starve_cnt_r  <= starve_next_s;
      pending_cnt_r <= popcount32(pending_next_s);
      issue_error_r <= issue_error_r | reissue_err_s | orphan_err_s;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural scoreboard model.
module tb_regfile_write_arbiter;

  localparam int LIMIT = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        PipeWrite, LongValid, IssueLong;
  logic [4:0]  PipeAddr, LongAddr, IssueAddr, RsAddr, RtAddr;
  logic [31:0] PipeData, LongData;
  logic        PipeStall, LongReady, RsBusy, RtBusy, RegWrite, IssueError;
  logic [4:0]  RdAddr;
  logic [31:0] RdData;
  logic [5:0]  PendingCount;

  int checks = 0;
  int errors = 0;

  bit [31:0] m_pend;
  int        m_starve;
  bit        m_err;
  bit        prev_long_acc;
  bit        prev_pipe_stall;

  regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .PipeWrite(PipeWrite), .PipeAddr(PipeAddr), .PipeData(PipeData), .PipeStall(PipeStall),
    .LongValid(LongValid), .LongAddr(LongAddr), .LongData(LongData), .LongReady(LongReady),
    .IssueLong(IssueLong), .IssueAddr(IssueAddr),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsBusy(RsBusy), .RtBusy(RtBusy),
    .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData),
    .PendingCount(PendingCount), .IssueError(IssueError)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_grant_long();
    return !Reset && LongValid && (!PipeWrite || m_starve == LIMIT);
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  // Reference model: scoreboard as a plain bit set, starvation as an integer.
  always @(posedge Clock or posedge Reset) begin
    bit        gl;
    bit [31:0] p;
    bit        e;
    if (Reset) begin
      m_pend   <= '0;
      m_starve <= 0;
      m_err    <= 1'b0;
    end else begin
      gl = model_grant_long();
      p  = m_pend;
      e  = m_err;
      if (gl && LongAddr != 0) begin
        if (!m_pend[LongAddr]) e = 1'b1;
        p[LongAddr] = 1'b0;
      end
      if (IssueLong && IssueAddr != 0) begin
        if (m_pend[IssueAddr] && !(gl && LongAddr == IssueAddr)) e = 1'b1;
        p[IssueAddr] = 1'b1;
      end
      m_pend   <= p;
      m_err    <= e;
      m_starve <= (LongValid && !gl) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    bit          gl, gp, stall, we;
    logic [4:0]  a;
    logic [31:0] d;
    gl    = model_grant_long();
    gp    = !Reset && PipeWrite && !gl;
    stall = PipeWrite && gl;
    a     = gl ? LongAddr : (gp ? PipeAddr : 5'd0);
    d     = gl ? LongData : (gp ? PipeData : 32'd0);
    we    = (gl || gp) && (a != 0);
    check("LongReady", LongReady, gl);
    check("PipeStall", PipeStall, stall);
    check("RegWrite", RegWrite, we);
    check("RdAddr", RdAddr, a);
    check("RdData", RdData, d);
    check("RsBusy", RsBusy, m_pend[RsAddr]);
    check("RtBusy", RtBusy, m_pend[RtAddr]);
    check("PendingCount", PendingCount, model_count());
    check("IssueError", IssueError, m_err);
    prev_long_acc   = gl;
    prev_pipe_stall = stall;
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int cand[$];
    Reset = 1'b1;
    PipeWrite = 1'b0; PipeAddr = 5'd0; PipeData = 32'd0;
    LongValid = 1'b0; LongAddr = 5'd0; LongData = 32'd0;
    IssueLong = 1'b0; IssueAddr = 5'd0; RsAddr = 5'd0; RtAddr = 5'd0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    // Idle after reset
    repeat (3) cyc();
    #1;
    check("idle_we", RegWrite, 1'b0);
    check("idle_addr", RdAddr, 5'd0);
    check("idle_data", RdData, 32'd0);
    check("idle_cnt", PendingCount, 6'd0);
    check("idle_err", IssueError, 1'b0);

    // Pipe-only write
    PipeWrite = 1'b1; PipeAddr = 5'd5; PipeData = 32'hDEADBEEF;
    #1;
    check("pipe_we", RegWrite, 1'b1);
    check("pipe_addr", RdAddr, 5'd5);
    check("pipe_data", RdData, 32'hDEADBEEF);
    check("pipe_stall", PipeStall, 1'b0);
    cyc();
    PipeWrite = 1'b0;

    // Issue then long writeback
    IssueLong = 1'b1; IssueAddr = 5'd7;
    cyc();
    IssueLong = 1'b0; RtAddr = 5'd7;
    #1;
    check("issue_rtbusy", RtBusy, 1'b1);
    check("issue_cnt", PendingCount, 6'd1);
    LongValid = 1'b1; LongAddr = 5'd7; LongData = 32'h12;
    #1;
    check("long_ready", LongReady, 1'b1);
    check("long_we", RegWrite, 1'b1);
    check("long_data", RdData, 32'h12);
    cyc();
    LongValid = 1'b0;
    #1;
    check("wb_rtbusy", RtBusy, 1'b0);
    check("wb_cnt", PendingCount, 6'd0);

    // Starvation: long refused for LIMIT cycles, then forced through
    IssueLong = 1'b1; IssueAddr = 5'd10;
    cyc();
    IssueLong = 1'b0;
    PipeWrite = 1'b1; PipeAddr = 5'd4; PipeData = 32'hA5A5_0004;
    LongValid = 1'b1; LongAddr = 5'd10; LongData = 32'h0000_0010;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      check("starve_refused", LongReady, 1'b0);
      check("starve_pipe_addr", RdAddr, 5'd4);
      cyc();
    end
    #1;
    check("starve_forced", LongReady, 1'b1);
    check("starve_stall", PipeStall, 1'b1);
    check("starve_addr", RdAddr, 5'd10);
    cyc();
    LongValid = 1'b0;
    #1;
    check("held_pipe_stall", PipeStall, 1'b0);
    check("held_pipe_addr", RdAddr, 5'd4);
    check("held_pipe_data", RdData, 32'hA5A5_0004);
    cyc();

    // Register 0 and same-cycle set/clear
    PipeAddr = 5'd0; PipeData = 32'hFFFF_FFFF;
    #1;
    check("r0_we", RegWrite, 1'b0);
    check("r0_stall", PipeStall, 1'b0);
    cyc();
    PipeWrite = 1'b0; IssueLong = 1'b1; IssueAddr = 5'd0;
    cyc();
    IssueLong = 1'b0;
    #1;
    check("r0_issue_cnt", PendingCount, 6'd0);
    IssueLong = 1'b1; IssueAddr = 5'd9;
    cyc();
    LongValid = 1'b1; LongAddr = 5'd9; LongData = 32'h99;
    cyc();
    LongValid = 1'b0; IssueLong = 1'b0; RsAddr = 5'd9;
    #1;
    check("setclr_busy", RsBusy, 1'b1);
    check("setclr_cnt", PendingCount, 6'd1);
    check("setclr_err", IssueError, 1'b0);
    LongValid = 1'b1;
    cyc();
    LongValid = 1'b0;
    #1;
    check("setclr_drain", PendingCount, 6'd0);

    // Error: handshake to non-pending register, then sticky
    LongValid = 1'b1; LongAddr = 5'd3;
    cyc();
    LongValid = 1'b0;
    #1;
    check("err_set", IssueError, 1'b1);
    IssueLong = 1'b1; IssueAddr = 5'd3;
    cyc();
    IssueLong = 1'b0;
    repeat (2) cyc();
    #1;
    check("err_sticky", IssueError, 1'b1);
    RsAddr = 5'd3; PipeWrite = 1'b1; PipeAddr = 5'd6; PipeData = 32'h66;
    #1;
    check("pre_rst_busy", RsBusy, 1'b1);
    Reset = 1'b1;
    #1;
    check("arst_we", RegWrite, 1'b0);
    check("arst_addr", RdAddr, 5'd0);
    check("arst_busy", RsBusy, 1'b0);
    check("arst_cnt", PendingCount, 6'd0);
    check("arst_err", IssueError, 1'b0);
    Reset = 1'b0;
    cyc();
    PipeWrite = 1'b0;

    // Randomized traffic honouring the hold protocols
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (Reset) Reset = 1'b0;
      if (n % 400 == 399) begin
        Reset = 1'b1; LongValid = 1'b0; PipeWrite = 1'b0; IssueLong = 1'b0;
      end else begin
        cand.delete();
        for (int i = 1; i < 32; i++) if (m_pend[i]) cand.push_back(i);
        if (!(LongValid && !prev_long_acc)) begin
          LongValid = (cand.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
          if (cand.size() > 0 && $urandom_range(0, 9) != 0)
            LongAddr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
          else
            LongAddr = 5'($urandom_range(0, 31));
          LongData = $urandom;
        end
        if (!(PipeWrite && prev_pipe_stall)) begin
          PipeWrite = $urandom_range(0, 1) == 1;
          PipeAddr  = 5'($urandom_range(0, 31));
          PipeData  = $urandom;
        end
        IssueLong = $urandom_range(0, 3) == 0;
        IssueAddr = 5'($urandom_range(0, 31));
        RsAddr    = 5'($urandom_range(0, 31));
        RtAddr    = 5'($urandom_range(0, 31));
      end
    end
    cyc();
    Reset = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
